// File: rtl/exp_unit_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined exp unit.
package exp_unit_pipe_pkg;

    // Data width of the output buffer feeding the softmax path.
    localparam int OUTPUT_BUF_DATASIZE = 32;
    // log2(e) in Q.16 and the matching renormalising shift.
    localparam int LOG2E_Q             = 94548;
    localparam int LOG2E_SHIFT         = 16;
    // Number of register stages between input accept and out_valid.
    localparam int PIPE_DEPTH          = 4;

    typedef enum logic {
        MODE_EXP_X     = 1'b0,   // softmax stage 2: exp(Xi)
        MODE_EXP_X_LNF = 1'b1    // softmax stage 4: exp(Xi - lnF)
    } exp_mode_e;

    // 2^(idx / 2^addr_w) scaled by 2^frac_w, rounded to nearest.
    // Only ever evaluated at elaboration to build constant table entries.
    function automatic int exp2_lut_entry(input int idx, input int addr_w, input int frac_w);
        real v;
        v = (2.0 ** (real'(idx) / real'(32'sd1 << addr_w))) * real'(32'sd1 << frac_w);
        return $rtoi(v + 0.5);
    endfunction

endpackage

// File: rtl/exp_unit_pipe_if.sv
// Beat-level handshake bundle between the producer, the exp unit and the consumer.
interface exp_unit_pipe_if
    import exp_unit_pipe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int DATA_W = OUTPUT_BUF_DATASIZE
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_mode;
    logic [DATA_W-1:0]       in_lnf;
    logic [LANES*DATA_W-1:0] in_xi;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_exp;
    logic [LANES-1:0]        out_ovf;

    modport master (
        output in_valid, in_mode, in_lnf, in_xi, out_ready,
        input  in_ready, out_valid, out_exp, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, in_lnf, in_xi, out_ready,
        output in_ready, out_valid, out_exp, out_ovf
    );
endinterface

// File: rtl/exp_unit_pipe_lane.sv
// One exp lane: S1 scale/subtract, S2 multiply by log2(e), S3 split k/f and
// look up 2^f, S4 shift into place with saturation. All stages advance on en_i.
module exp_lane
    import exp_unit_pipe_pkg::*;
#(
    parameter int DATA_W     = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W     = 8,
    parameter int LUT_ADDR_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     mode_i,
    input  logic signed [DATA_W-1:0] lnf_i,
    input  logic signed [DATA_W-1:0] xi_i,
    output logic        [DATA_W-1:0] exp_o,
    output logic                     ovf_o
);
    localparam int X_W       = DATA_W + 1;
    localparam int P_W       = DATA_W + 18;
    localparam int T_W       = P_W - LOG2E_SHIFT;
    localparam int K_W       = T_W - FRAC_W;
    localparam int M_W       = FRAC_W + 1;
    localparam int SH_W      = $clog2(DATA_W);
    localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
    localparam logic signed [K_W-1:0] K_MAX = K_W'(DATA_W - FRAC_W - 1);
    localparam logic signed [K_W-1:0] K_MIN = K_W'(-(FRAC_W + 1));

    logic signed [X_W-1:0]      xs_s, x_d, x_q;
    logic signed [P_W-1:0]      prod_s;
    logic signed [T_W-1:0]      t_d, t_q;
    logic signed [K_W-1:0]      k_d, k_q;
    logic        [LUT_ADDR_W-1:0] idx_s;
    logic        [M_W-1:0]      m_d, m_q;
    logic        [SH_W-1:0]     lsh_s, rsh_s;
    logic        [DATA_W-1:0]   exp_d, exp_q;
    logic                       ovf_d, ovf_q;
    logic        [M_W-1:0]      lut_s [LUT_DEPTH];
    logic                       unused_bits_s;

    // Constant 2^f mantissa table, one entry per generate iteration.
    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        localparam logic [M_W-1:0] ENTRY = M_W'(exp2_lut_entry(g, LUT_ADDR_W, FRAC_W));
        assign lut_s[g] = ENTRY;
    end

    // Product fraction bits below the Q.16 point and sub-LUT fraction bits are dropped.
    assign unused_bits_s = ^{prod_s[LOG2E_SHIFT-1:0], t_q[FRAC_W-1:0]};

    // S1: Xi to fixed point; lnF only subtracted for stage-4 beats.
    always_comb begin
        xs_s = {xi_i[DATA_W-1], xi_i};
        if (mode_i == MODE_EXP_X_LNF) begin
            x_d = (xs_s <<< FRAC_W) - {lnf_i[DATA_W-1], lnf_i};
        end else begin
            x_d = xs_s <<< FRAC_W;
        end
    end

    // S2: convert natural exponent to base-2 exponent, floor on the shift.
    always_comb begin
        prod_s = P_W'(x_q) * P_W'(LOG2E_Q);
        t_d    = T_W'(prod_s >>> LOG2E_SHIFT);
    end

    // S3: integer part k and 2^f mantissa from the top fraction bits.
    always_comb begin
        k_d   = t_q[T_W-1:FRAC_W];
        idx_s = t_q[FRAC_W-1 -: LUT_ADDR_W];
        m_d   = lut_s[idx_s];
    end

    // S4: place the mantissa by k, saturating above range and flushing below.
    always_comb begin
        exp_d = '0;
        ovf_d = 1'b0;
        lsh_s = k_q[SH_W-1:0];
        rsh_s = SH_W'(-k_q);
        if (k_q > K_MAX) begin
            exp_d = '1;
            ovf_d = 1'b1;
        end else if (!k_q[K_W-1]) begin
            exp_d = DATA_W'(m_q) << lsh_s;
        end else if (k_q >= K_MIN) begin
            exp_d = DATA_W'(m_q >> rsh_s);
        end else begin
            exp_d = '0;
        end
    end

    // Stage registers; the whole lane freezes while the pipe is stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q   <= '0;
            t_q   <= '0;
            k_q   <= '0;
            m_q   <= '0;
            exp_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            x_q   <= x_d;
            t_q   <= t_d;
            k_q   <= k_d;
            m_q   <= m_d;
            exp_q <= exp_d;
            ovf_q <= ovf_d;
        end
    end

    assign exp_o = exp_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/exp_unit_pipe.sv
// Multi-lane pipelined fixed-point exp unit. Owns the beat valid chain and the
// whole-pipe stall; each lane carries its own datapath registers.
module exp_unit_pipe
    import exp_unit_pipe_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_W     = OUTPUT_BUF_DATASIZE,
    parameter int FRAC_W     = 8,
    parameter int LUT_ADDR_W = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    exp_unit_pipe_if.slave bus
);
    logic [PIPE_DEPTH-1:0]   vld_q;
    logic                    en_s;
    logic [LANES*DATA_W-1:0] exp_s;
    logic [LANES-1:0]        ovf_s;

    // The pipe only advances when the output slot is free or being drained.
    assign en_s = !vld_q[PIPE_DEPTH-1] || bus.out_ready;

    // Valid chain tracking which stages hold a real beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else if (en_s) begin
            vld_q <= {vld_q[PIPE_DEPTH-2:0], bus.in_valid};
        end
    end

    // mode/lnF are folded into x at S1, so they travel with the beat inside each lane.
    for (genvar n = 0; n < LANES; n++) begin : g_lane
        exp_lane #(
            .DATA_W    (DATA_W),
            .FRAC_W    (FRAC_W),
            .LUT_ADDR_W(LUT_ADDR_W)
        ) u_lane (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (en_s),
            .mode_i(bus.in_mode),
            .lnf_i (bus.in_lnf),
            .xi_i  (bus.in_xi[n*DATA_W +: DATA_W]),
            .exp_o (exp_s[n*DATA_W +: DATA_W]),
            .ovf_o (ovf_s[n])
        );
    end

    assign bus.in_ready  = en_s;
    assign bus.out_valid = vld_q[PIPE_DEPTH-1];
    assign bus.out_exp   = exp_s;
    assign bus.out_ovf   = ovf_s;

endmodule

// File: tb/tb_exp_unit_pipe.sv
// Directed-vector and streaming scoreboard bench for exp_unit_pipe.
module tb_exp_unit_pipe;

    typedef struct {
        logic         mode;
        logic [31:0]  lnf;
        logic [127:0] xi;
        logic [127:0] exp;
        logic [3:0]   ovf;
    } vec_t;

    typedef struct packed {
        logic [127:0] exp;
        logic [3:0]   ovf;
    } res_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_cmp = 0;
    int     n_bad = 0;
    longint lut_ref [64];
    vec_t   vecs [8];
    res_t   sb [$];

    exp_unit_pipe_if #(.LANES(4), .DATA_W(32)) bus ();

    exp_unit_pipe #(
        .LANES(4), .DATA_W(32), .FRAC_W(8), .LUT_ADDR_W(6)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [131:0] got, input logic [131:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    // Reference lane: exact integer arithmetic of the exp algorithm.
    function automatic logic [31:0] ref_lane(input logic mode, input logic [31:0] lnf,
                                              input logic [31:0] xi, output logic ovf);
        longint x, t, k, m;
        x = longint'($signed(xi)) * 64'sd256;
        if (mode) x = x - longint'($signed(lnf));
        t = (x * 64'sd94548) >>> 16;
        k = t >>> 8;
        m = lut_ref[int'(t & 64'sd255) >> 2];
        ovf = 1'b0;
        if (k > 23) begin
            ovf = 1'b1;
            return 32'hFFFF_FFFF;
        end else if (k >= 0) begin
            return 32'(m << k);
        end else if (k >= -9) begin
            return 32'(m >> (-k));
        end else begin
            return 32'h0;
        end
    endfunction

    function automatic res_t ref_beat(input logic mode, input logic [31:0] lnf, input logic [127:0] xi);
        res_t r;
        logic o;
        for (int l = 0; l < 4; l++) begin
            r.exp[l*32 +: 32] = ref_lane(mode, lnf, xi[l*32 +: 32], o);
            r.ovf[l] = o;
        end
        return r;
    endfunction

    // Send one beat into an idle pipe, measure latency in edges (accept edge = 1) and check.
    task automatic run_vec(input vec_t v, input string name);
        int lat;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_mode   = v.mode;
        bus.in_lnf    = v.lnf;
        bus.in_xi     = v.xi;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 132'(lat), 132'(4));
        chk({name, "_exp"}, 132'(bus.out_exp), 132'(v.exp));
        chk({name, "_ovf"}, 132'(bus.out_ovf), 132'(v.ovf));
        @(posedge clk);
    endtask

    initial begin
        int   sent, rcvd, vcount;
        logic pending, held_v;
        logic [132:0] held;
        res_t got_r, exp_r;

        for (int i = 0; i < 64; i++)
            lut_ref[i] = longint'($rtoi($floor((2.0 ** (real'(i) / 64.0)) * 256.0 + 0.5)));

        vecs[0] = '{1'b0, 32'h0, {4{32'h0}}, {4{32'h100}}, 4'b0000};
        vecs[1] = '{1'b0, 32'h0, {4{32'h1}}, {4{32'h2B6}}, 4'b0000};
        vecs[2] = '{1'b1, 32'hA00, {4{32'h5}}, {4{32'h1}}, 4'b0000};
        vecs[3] = '{1'b0, 32'h0, {32'h0, 32'h1E, 32'h0, 32'h0},
                    {32'h100, 32'hFFFF_FFFF, 32'h100, 32'h100}, 4'b0100};
        vecs[4] = '{1'b1, 32'h0001_0000, {4{32'h0}}, {4{32'h0}}, 4'b0000};
        vecs[5] = '{1'b0, 32'h0, {32'h11, 32'h10, 32'h2, 32'hFFFF_FFFF},
                    {32'hFFFF_FFFF, 32'h8700_0000, 32'h758, 32'h5D}, 4'b1000};
        vecs[6] = '{1'b0, 32'h0, {32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFB},
                    {32'h100, 32'h0, 32'h0, 32'h1}, 4'b0000};
        vecs[7] = '{1'b1, 32'hFFFF_FF00, {4{32'h0}}, {4{32'h2B6}}, 4'b0000};

        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_lnf    = 32'h0;
        bus.in_xi     = 128'h0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 132'(bus.out_valid), 132'(0));
        chk("rst_exp",   132'(bus.out_exp),   132'(0));
        chk("rst_ovf",   132'(bus.out_ovf),   132'(0));
        chk("rst_ready", 132'(bus.in_ready),  132'(1));

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Streaming with random backpressure and alternating mode/lnF.
        sent = 0; rcvd = 0; pending = 1'b0; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 800 && rcvd < 20; cyc++) begin
            @(negedge clk);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            if (!pending && sent < 20 && $urandom_range(0, 3) != 0) begin
                bus.in_mode = sent[0];
                bus.in_lnf  = sent[0] ? 32'(int'($urandom_range(0, 8192)) - 4096)
                                      : (32'hDEAD_0000 ^ 32'(sent));
                for (int l = 0; l < 4; l++)
                    bus.in_xi[l*32 +: 32] = 32'(int'($urandom_range(0, 40)) - 20);
                pending = 1'b1;
            end
            bus.in_valid = pending;
            #1;
            if (held_v) chk("stall_hold", 132'({bus.out_valid, bus.out_exp, bus.out_ovf}), 132'(held));
            if (bus.out_valid && !bus.out_ready) chk("stall_in_ready", 132'(bus.in_ready), 132'(0));
            held_v = bus.out_valid && !bus.out_ready;
            held   = {bus.out_valid, bus.out_exp, bus.out_ovf};
            if (bus.out_valid && bus.out_ready) begin
                got_r = '{bus.out_exp, bus.out_ovf};
                if (sb.size() == 0) begin
                    chk("stream_extra_beat", 132'(got_r), 132'(0));
                end else begin
                    exp_r = sb.pop_front();
                    chk($sformatf("stream_beat%0d", rcvd), 132'(got_r), 132'(exp_r));
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(ref_beat(bus.in_mode, bus.in_lnf, bus.in_xi));
                sent++;
                pending = 1'b0;
            end
        end
        chk("stream_rcvd", 132'(rcvd), 132'(20));
        chk("stream_sb_empty", 132'(sb.size()), 132'(0));

        // Reset with three beats in flight.
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_mode  = 1'b0;
            bus.in_lnf   = 32'h0;
            bus.in_xi    = {4{32'h3}};
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 132'(bus.out_valid), 132'(0));
        chk("midrst_exp",   132'(bus.out_exp),   132'(0));
        chk("midrst_ovf",   132'(bus.out_ovf),   132'(0));
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) vcount++;
        end
        chk("midrst_no_stale", 132'(vcount), 132'(0));
        run_vec(vecs[1], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
